param_grf: RTL
==============

PARAM_GRF -- requirements
Module: param_grf

Interface
REQ-001 SHALL expose parameter DATA_W, default 32, register data width.
REQ-002 SHALL expose parameter ADDR_W, default 5, register index width; depth = 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports we0/we1  input  1  write-port enables; port 1 has priority.
REQ-006 SHALL have ports wa0/wa1  input  ADDR_W  write addresses.
REQ-007 SHALL have ports wd0/wd1  input  DATA_W  write data.
REQ-008 SHALL have ports ra1/ra2  input  ADDR_W  read addresses.
REQ-009 SHALL have ports rd1/rd2  output  DATA_W  read data, combinational from ra1/ra2.
REQ-010 SHALL have port iss_en  input  1  request to register a pending write (instruction issue).
REQ-011 SHALL have port iss_rd  input  ADDR_W  destination of the issued write.
REQ-012 SHALL have port iss_rej  output  1  issue refused because the destination counter is saturated.
REQ-013 SHALL have ports busy1/busy2  output  1  a write to ra1/ra2 is still pending.

Function
REQ-014 SHALL hold an array of 2**ADDR_W registers of DATA_W bits; index 0 SHALL read 0 and ignore writes.
REQ-015 SHALL commit an enabled write with nonzero address on the clk rising edge.
REQ-016 SHALL commit only wd1 when we0 and we1 target the same nonzero address in one cycle.
REQ-017 SHALL keep a 2-bit pending counter per register; index 0's counter SHALL stay 0.
REQ-018 SHALL increment the counter of iss_rd on an accepted issue (iss_en=1, iss_rd!=0, counter<3).
REQ-019 SHALL assert iss_rej combinationally when iss_en=1, iss_rd!=0 and counter(iss_rd)==3; the counter SHALL be left unchanged.
REQ-020 SHALL decrement a counter by one for each enabled write port targeting it that cycle, flooring at 0.
REQ-021 SHALL apply increment and decrements to the same register in one cycle as a net change (e.g. cnt 1, issue + one write -> 1).
REQ-022 SHALL evaluate iss_rej against the current counter value, not the same-cycle post-write value.
REQ-023 SHALL drive busyN = (counter(raN) != 0) with raN=0 giving busyN=0.
REQ-024 SHALL have no read latency: rdN reflects state plus the bypass rule of REQ-030/031.

Reset
REQ-025 SHALL, on reset=0, asynchronously clear all registers and all counters to 0.
REQ-026 SHALL drive rd1/rd2=0, busy1/busy2=0 and iss_rej=0 while reset=0, regardless of other inputs.
REQ-027 SHALL discard any write or issue coinciding with reset assertion; no partial update.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Configuration
REQ-029 SHALL use macro GRF_BYPASS_EN to select same-cycle write forwarding.
REQ-030 With GRF_BYPASS_EN defined, rdN SHALL return the winning same-cycle write data (wd1 over wd0) when raN matches an enabled nonzero write address, and busyN SHALL use the counter after that cycle's decrements.
REQ-031 Without GRF_BYPASS_EN, rdN and busyN SHALL reflect only stored state; the write becomes visible the cycle after commit.

Verification
REQ-032 Reset: hold reset=0, pulse clk with we0=1 wa0=3 wd0=0xAAAA -> rd1(ra1=3)=0 after release.
REQ-033 Write conflict: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> next cycle rd1(ra1=7)=0x22; wa=0 writes -> rd1(ra1=0)=0.
REQ-034 Bypass: we0=1 wa0=5 wd0=0x1234, ra1=5 same cycle -> rd1=0x1234 with GRF_BYPASS_EN, rd1=old value (0) without.
REQ-035 Scoreboard: issue rd=9 three times -> busy1(ra1=9)=1; fourth issue -> iss_rej=1, counter stays 3; one write to 9 -> counter 2, busy stays 1.
REQ-036 Net update: counter(4)=1, iss_en=1 iss_rd=4 and we1=1 wa1=4 same cycle -> counter remains 1, busy1(ra1=4)=1; two more writes -> busy1=0, extra write leaves counter 0.
REQ-037 Async reset mid-operation: counters nonzero, drop reset between clk edges -> busy1/busy2 and rd1/rd2 go 0 immediately, before next clk edge.

Source files
------------

// File: rtl/param_grf.sv
// Two-write/two-read register file with a 2-bit pending-write scoreboard; GRF_BYPASS_EN enables same-cycle write forwarding.
// Latency: reads, busy flags and iss_rej are combinational; writes and counter updates take effect on the next clk rising edge.
// Backpressure: iss_rej refuses an issue whose destination counter is saturated; writes are always accepted.
module param_grf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_rej,
    output logic              busy1,
    output logic              busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wr_t;

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [1:0]        cnt      [DEPTH];
    logic [1:0]        cnt_nxt  [DEPTH];
    logic [1:0]        cnt_post [DEPTH];

    wr_t  wr0;
    wr_t  wr1;
    logic iss_sat;
    logic iss_ok;

    // Writes to index 0 are dropped here so nothing downstream needs to care.
    always_comb begin
        wr0.vld  = we0 && (wa0 != '0);
        wr0.addr = wa0;
        wr0.dat  = wd0;
        wr1.vld  = we1 && (wa1 != '0);
        wr1.addr = wa1;
        wr1.dat  = wd1;
    end

    // Saturation is judged on the stored counter, before this cycle's writes.
    assign iss_sat = (cnt[iss_rd] == 2'd3);
    assign iss_ok  = iss_en && (iss_rd != '0) && !iss_sat;
    assign iss_rej = reset && iss_en && (iss_rd != '0) && iss_sat;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [2:0] sum;
            logic [2:0] dec;
            sum = {1'b0, cnt[i]};
            dec = 3'd0;
            if (iss_ok && (iss_rd == ADDR_W'(i)))
                sum = sum + 3'd1;
            if (wr0.vld && (wr0.addr == ADDR_W'(i)))
                dec = dec + 3'd1;
            if (wr1.vld && (wr1.addr == ADDR_W'(i)))
                dec = dec + 3'd1;
            // Net change with a floor at zero; never exceeds 3 because saturated issues are refused.
            cnt_nxt[i]  = (sum > dec) ? 2'(sum - dec) : 2'd0;
            cnt_post[i] = ({1'b0, cnt[i]} > dec) ? 2'({1'b0, cnt[i]} - dec) : 2'd0;
            if (i == 0) begin
                cnt_nxt[i]  = 2'd0;
                cnt_post[i] = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= cnt_nxt[i];
        end
    end

    // Port 1 wins an address collision; index 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr1.vld && (wr1.addr == ADDR_W'(i)))
                    regs[i] <= wr1.dat;
                else if (wr0.vld && (wr0.addr == ADDR_W'(i)))
                    regs[i] <= wr0.dat;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra,
                                                    input wr_t w0, input wr_t w1,
                                                    input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] val;
        val = (ra == '0) ? '0 : stored;
`ifdef GRF_BYPASS_EN
        if (w1.vld && (w1.addr == ra))
            val = w1.dat;
        else if (w0.vld && (w0.addr == ra))
            val = w0.dat;
`else
        if (w0.vld && w1.vld && (w0.addr == ra) && (w1.addr == ra))
            val = val;
`endif
        return val;
    endfunction

    logic [DATA_W-1:0] rd1_raw;
    logic [DATA_W-1:0] rd2_raw;
    logic              busy1_raw;
    logic              busy2_raw;

    assign rd1_raw = read_port(ra1, wr0, wr1, regs[ra1]);
    assign rd2_raw = read_port(ra2, wr0, wr1, regs[ra2]);

`ifdef GRF_BYPASS_EN
    assign busy1_raw = (cnt_post[ra1] != 2'd0);
    assign busy2_raw = (cnt_post[ra2] != 2'd0);
`else
    assign busy1_raw = (cnt[ra1] != 2'd0);
    assign busy2_raw = (cnt[ra2] != 2'd0);
`endif

    // Outputs are forced quiet while reset is held, even if forwarding would match.
    assign rd1   = reset ? rd1_raw : '0;
    assign rd2   = reset ? rd2_raw : '0;
    assign busy1 = reset && busy1_raw;
    assign busy2 = reset && busy2_raw;

endmodule
